// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : clocked unsigned integer ALU with four result registers.
//
// A start pulse (sampled on a rising clk edge while busy=0) launches one
// operation selected by sel:
//   00 add       -> sum  (WIDTH+1 bits, carry in MSB), one clock
//   01 subtract  -> sub  (WIDTH+1 bits two's complement, MSB = borrow), one clock
//   10 multiply  -> mul  (2*WIDTH bits, full product), one clock
//   11 divide    -> div  (WIDTH bits quotient) + dbz, WIDTH clocks (restoring)
// Only the result port of the completed operation changes; the others hold.
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   start in   launch request, ignored while busy
//   a, b  in   WIDTH-bit unsigned operands
//   sel   in   2-bit operation select
//   sum, sub, mul, div  out  registered results
//   busy  out  high while a divide is iterating
//   done  out  one-cycle pulse per completed result
//   dbz   out  divide-by-zero flag, updated only by divides
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           sel,
  output logic [WIDTH:0]       sum,
  output logic [WIDTH:0]       sub,
  output logic [2*WIDTH-1:0]   mul,
  output logic [WIDTH-1:0]     div,
  output logic                 busy,
  output logic                 done,
  output logic                 dbz
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  state_t               state_r, state_s;

  // Divider working registers: quot_r starts as the dividend and is shifted
  // left, its MSB feeding the partial remainder while quotient bits enter LSB.
  logic [WIDTH-1:0]     rem_r, rem_s;
  logic [WIDTH-1:0]     quot_r, quot_s;
  logic [WIDTH-1:0]     dvsr_r, dvsr_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;

  // Next values of the output registers
  logic [WIDTH:0]       sum_s, sub_s;
  logic [2*WIDTH-1:0]   mul_s;
  logic [WIDTH-1:0]     div_s;
  logic                 busy_s, done_s, dbz_s;

  // One restoring step
  logic [WIDTH:0]       rem_shift_s;
  logic [WIDTH:0]       trial_s;
  logic                 q_bit_s;
  logic [WIDTH-1:0]     rem_step_s;
  logic [WIDTH-1:0]     quot_step_s;

  // Restoring divide step: the partial remainder is always below the divisor,
  // so the shifted value minus the divisor lies in (-2^WIDTH, 2^WIDTH) and its
  // MSB is a clean sign bit telling whether the subtraction "fits".
  always_comb begin
    rem_shift_s = {rem_r, quot_r[WIDTH-1]};
    trial_s     = rem_shift_s - {1'b0, dvsr_r};
    q_bit_s     = ~trial_s[WIDTH];
    if (q_bit_s) begin
      rem_step_s = trial_s[WIDTH-1:0];
    end else begin
      rem_step_s = rem_shift_s[WIDTH-1:0];
    end
    quot_step_s = {quot_r[WIDTH-2:0], q_bit_s};
  end

  // Next-state and next-output decode
  always_comb begin
    state_s = state_r;
    sum_s   = sum;
    sub_s   = sub;
    mul_s   = mul;
    div_s   = div;
    busy_s  = busy;
    dbz_s   = dbz;
    done_s  = 1'b0;
    rem_s   = rem_r;
    quot_s  = quot_r;
    dvsr_s  = dvsr_r;
    cnt_s   = cnt_r;

    case (state_r)
      ST_IDLE: begin
        // busy is always 0 in IDLE, so any start here is an acceptance edge
        if (start) begin
          case (sel)
            2'b00: begin
              sum_s  = {1'b0, a} + {1'b0, b};
              done_s = 1'b1;
            end
            2'b01: begin
              sub_s  = {1'b0, a} - {1'b0, b};
              done_s = 1'b1;
            end
            2'b10: begin
              mul_s  = (2*WIDTH)'(a) * (2*WIDTH)'(b);
              done_s = 1'b1;
            end
            2'b11: begin
              if (b == {WIDTH{1'b0}}) begin
                div_s  = {WIDTH{1'b1}};
                dbz_s  = 1'b1;
                done_s = 1'b1;
              end else begin
                state_s = ST_DIV;
                busy_s  = 1'b1;
                quot_s  = a;
                dvsr_s  = b;
                rem_s   = {WIDTH{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
              end
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_DIV: begin
        rem_s  = rem_step_s;
        quot_s = quot_step_s;
        if (cnt_r == CNT_LAST) begin
          div_s   = quot_step_s;
          dbz_s   = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          cnt_s   = {CNT_W{1'b0}};
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, divider and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      rem_r   <= {WIDTH{1'b0}};
      quot_r  <= {WIDTH{1'b0}};
      dvsr_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      sum     <= {(WIDTH+1){1'b0}};
      sub     <= {(WIDTH+1){1'b0}};
      mul     <= {(2*WIDTH){1'b0}};
      div     <= {WIDTH{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      state_r <= state_s;
      rem_r   <= rem_s;
      quot_r  <= quot_s;
      dvsr_r  <= dvsr_s;
      cnt_r   <= cnt_s;
      sum     <= sum_s;
      sub     <= sub_s;
      mul     <= mul_s;
      div     <= div_s;
      busy    <= busy_s;
      done    <= done_s;
      dbz     <= dbz_s;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq : directed self-checking bench for alu_seq (WIDTH=8).
// Inputs are driven on the falling edge and outputs sampled on the falling
// edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  sel;
  logic [8:0]  sum;
  logic [8:0]  sub;
  logic [15:0] mul;
  logic [7:0]  div;
  logic        busy;
  logic        done;
  logic        dbz;

  int tests;
  int fails;
  int lat;
  int done_seen;

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .sum   (sum),
    .sub   (sub),
    .mul   (mul),
    .div   (div),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the launch edge.
  task automatic launch(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] is);
    a     = ia;
    b     = ib;
    sel   = is;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done is seen; 0 means done is already high.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    sel   = 2'b00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_sum",  32'(sum),  32'h0);
    chk("rst_sub",  32'(sub),  32'h0);
    chk("rst_mul",  32'(mul),  32'h0);
    chk("rst_div",  32'(div),  32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_dbz",  32'(dbz),  32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a divide aborts it
    launch(8'd200, 8'd7, 2'b11);
    chk("div_busy_set", 32'(busy), 32'h1);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_div",  32'(div),  32'h0);
    chk("abort_done", 32'(done), 32'h0);
    #1 rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    chk("abort_no_done", 32'(done_seen), 32'h0);
    chk("abort_idle",    32'(busy),      32'h0);

    // Full divide 200/7, latency WIDTH clocks from acceptance
    launch(8'd200, 8'd7, 2'b11);
    wait_done(lat);
    chk("div200_lat",  32'(lat),  32'd8);
    chk("div200_q",    32'(div),  32'd28);
    chk("div200_dbz",  32'(dbz),  32'h0);
    chk("div200_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("div200_done_pulse", 32'(done), 32'h0);

    // Add with carry; other results hold
    launch(8'd200, 8'd100, 2'b00);
    chk("add_done", 32'(done), 32'h1);
    chk("add_sum",  32'(sum),  32'h12C);
    chk("add_sub",  32'(sub),  32'h0);
    chk("add_mul",  32'(mul),  32'h0);
    chk("add_div",  32'(div),  32'd28);
    @(negedge clk);
    chk("add_done_pulse", 32'(done), 32'h0);

    // Subtract with and without borrow
    launch(8'd3, 8'd5, 2'b01);
    chk("sub_borrow", 32'(sub), 32'h1FE);
    chk("sub_sum",    32'(sum), 32'h12C);
    chk("sub_done",   32'(done), 32'h1);
    launch(8'd5, 8'd3, 2'b01);
    chk("sub_pos", 32'(sub), 32'h002);

    // Multiply corners
    launch(8'd255, 8'd255, 2'b10);
    chk("mul_max", 32'(mul), 32'hFE01);
    chk("mul_sub", 32'(sub), 32'h002);
    launch(8'd0, 8'd77, 2'b10);
    chk("mul_zero", 32'(mul), 32'h0);

    // Divide corners
    launch(8'd255, 8'd1, 2'b11);
    wait_done(lat);
    chk("div255_lat", 32'(lat), 32'd8);
    chk("div255_q",   32'(div), 32'd255);
    @(negedge clk);
    launch(8'd6, 8'd7, 2'b11);
    wait_done(lat);
    chk("div6_q", 32'(div), 32'd0);
    @(negedge clk);

    // Divide by zero: immediate, no busy
    launch(8'd9, 8'd0, 2'b11);
    chk("dbz_done", 32'(done), 32'h1);
    chk("dbz_busy", 32'(busy), 32'h0);
    chk("dbz_q",    32'(div),  32'hFF);
    chk("dbz_flag", 32'(dbz),  32'h1);
    launch(8'd1, 8'd1, 2'b00);
    chk("dbz_hold_sum",  32'(sum), 32'h002);
    chk("dbz_hold_flag", 32'(dbz), 32'h1);
    launch(8'd9, 8'd3, 2'b11);
    wait_done(lat);
    chk("div9_q",   32'(div), 32'd3);
    chk("div9_dbz", 32'(dbz), 32'h0);
    @(negedge clk);

    // Busy lockout: add while busy is ignored, operands latched
    launch(8'd100, 8'd9, 2'b11);
    a     = 8'd1;
    b     = 8'd1;
    sel   = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("lock_busy", 32'(busy), 32'h1);
    chk("lock_sum",  32'(sum),  32'h002);
    wait_done(lat);
    chk("lock_q",   32'(div), 32'd11);
    chk("lock_sum2", 32'(sum), 32'h002);

    // Back-to-back add then multiply with start held
    a     = 8'd10;
    b     = 8'd20;
    sel   = 2'b00;
    start = 1'b1;
    @(negedge clk);
    chk("b2b_sum",   32'(sum),  32'd30);
    chk("b2b_done1", 32'(done), 32'h1);
    sel = 2'b10;
    @(negedge clk);
    chk("b2b_mul",   32'(mul),  32'd200);
    chk("b2b_done2", 32'(done), 32'h1);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done_end", 32'(done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
